pulse_interval_capture: RTL

PULSE_INTERVAL_CAPTURE -- requirements
Module: pulse_interval_capture

---
 rtl/pulse_interval_capture.sv | 82 ++++++++
 1 files changed

// File: rtl/pulse_interval_capture.sv
// pulse_interval_capture: measures cycles between rising edges of signal_in and hands each interval over a valid/ready port.
// Define PULSE_CAPTURE_GRAY_OUTPUT_EN to present sample_interval Gray-encoded.
module pulse_interval_capture #(
    parameter int MAX_COUNT = 65535,
    localparam int W = $clog2(MAX_COUNT + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         signal_in,
    input  logic         sample_ready,
    input  logic         overrun_clear,
    output logic         sample_valid,
    output logic [W-1:0] sample_interval,
    output logic         sample_overflow,
    output logic         overrun,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ARMED, COUNTING} state_t;
    localparam logic [W-1:0] MAX = W'(MAX_COUNT);
    state_t state_q, state_d;
    logic [W-1:0] count_q, count_d, interval_q, interval_d, cap_code;
    logic prev_q, valid_q, valid_d, ovf_q, ovf_d, overrun_q, overrun_d;
    logic rise, sat, capture;
    assign rise    = signal_in & ~prev_q;
    assign sat     = count_q == MAX;
    assign capture = enable && state_q == COUNTING && rise;
`ifdef PULSE_CAPTURE_GRAY_OUTPUT_EN
    assign cap_code = count_q ^ (count_q >> 1);
`else
    assign cap_code = count_q;
`endif
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (!enable) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE:     state_d = ARMED;
                ARMED:    if (rise) begin
                    state_d = COUNTING;
                    count_d = W'(1);
                end
                COUNTING: count_d = rise ? W'(1) : sat ? count_q : count_q + W'(1);
                default:  state_d = IDLE;
            endcase
        end
    end
    always_comb begin
        interval_d = capture ? cap_code : interval_q;
        ovf_d      = capture ? sat : ovf_q;
        valid_d    = capture | (valid_q & ~sample_ready);
        // Overwriting an unconsumed sample beats a simultaneous clear.
        overrun_d  = (capture & valid_q & ~sample_ready) | (overrun_q & ~overrun_clear);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            prev_q     <= 1'b0;
            valid_q    <= 1'b0;
            interval_q <= '0;
            ovf_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            prev_q     <= signal_in;
            valid_q    <= valid_d;
            interval_q <= interval_d;
            ovf_q      <= ovf_d;
            overrun_q  <= overrun_d;
        end
    end
    assign sample_valid    = valid_q;
    assign sample_interval = interval_q;
    assign sample_overflow = ovf_q;
    assign overrun         = overrun_q;
    assign busy            = state_q != IDLE;
endmodule
